// File: rtl/pulse_cnt_frame_tx.sv
// ---------------------------------------------------------------------------
// pulse_cnt_frame_tx
//   Snapshots the four channel counts of the pulse counter when the gating
//   enable closes (i_en 1->0) and sends them as one fixed-length byte frame
//   on a valid/ready byte stream:
//     HDR, cnt0 (MSB byte first) .. cnt3, CHK (XOR of every preceding byte)
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous reset, active-HIGH (legacy name kept)
//   i_en       : counter gate enable
//   i_cnt0..3  : channel counts, CNT_W bits each
//   o_tdata    : frame byte
//   o_tvalid   : o_tdata valid
//   i_tready   : sink ready; a byte moves when o_tvalid & i_tready at clk edge
//   o_busy     : high from fall detect until the last byte is accepted
//   o_overrun  : one-cycle pulse when a window close is dropped while busy
// ---------------------------------------------------------------------------
module pulse_cnt_frame_tx #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned CAP_DLY = 2,
    parameter logic [7:0]  HDR     = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_cnt0,
    input  logic [CNT_W-1:0] i_cnt1,
    input  logic [CNT_W-1:0] i_cnt2,
    input  logic [CNT_W-1:0] i_cnt3,
    output logic [7:0]       o_tdata,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic             o_busy,
    output logic             o_overrun
);

    localparam int unsigned BODY_LEN  = 4 * (CNT_W / 8);
    localparam int unsigned FRAME_LEN = BODY_LEN + 2;
    localparam int unsigned FRAME_W   = FRAME_LEN * 8;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam int unsigned DLY_W     = $clog2(CAP_DLY + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [DLY_W-1:0] DLY_DONE = DLY_W'(CAP_DLY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    // Checksum: header XOR every body byte.
    function automatic logic [7:0] frame_chk(input logic [4*CNT_W-1:0] body);
        logic [7:0] acc;
        acc = HDR;
        for (int i = 0; i < int'(BODY_LEN); i++) begin
            acc = acc ^ body[i*8 +: 8];
        end
        return acc;
    endfunction

    // Byte idx of the frame; byte 0 sits in the top bits.
    function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] frame,
                                              input logic [IDX_W-1:0]   idx);
        logic [7:0] sel;
        sel = 8'h00;
        for (int i = 0; i < int'(FRAME_LEN); i++) begin
            if (idx == IDX_W'(i)) begin
                sel = frame[(int'(FRAME_LEN) - 1 - i)*8 +: 8];
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

    state_t             state_r, state_nxt;
    logic               en_d_r;
    logic [DLY_W-1:0]   dly_r, dly_nxt;
    logic [IDX_W-1:0]   idx_r, idx_nxt;
    logic [7:0]         tdata_r, tdata_nxt;
    logic               tvalid_r, tvalid_nxt;
    logic               busy_r, busy_nxt;
    logic               overrun_r, overrun_nxt;
    logic [FRAME_W-1:0] frame_r;
    logic [4*CNT_W-1:0] body_s;
    logic [FRAME_W-1:0] frame_new_s;
    logic               fall_s;
    logic               snap_en_s;

    assign fall_s      = en_d_r & ~i_en;
    assign body_s      = {i_cnt0, i_cnt1, i_cnt2, i_cnt3};
    assign frame_new_s = {HDR, body_s, frame_chk(body_s)};

    assign o_tdata   = tdata_r;
    assign o_tvalid  = tvalid_r;
    assign o_busy    = busy_r;
    assign o_overrun = overrun_r;

    // Enable delay register for falling-edge detection.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            en_d_r <= 1'b0;
        end else begin
            en_d_r <= i_en;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_nxt   = state_r;
        dly_nxt     = dly_r;
        idx_nxt     = idx_r;
        tdata_nxt   = tdata_r;
        tvalid_nxt  = tvalid_r;
        busy_nxt    = busy_r;
        snap_en_s   = 1'b0;

        // A close seen while anything is in flight (including the edge that
        // accepts the last byte) is dropped and flagged.
        if (fall_s && (state_r != ST_IDLE)) begin
            overrun_nxt = 1'b1;
        end else begin
            overrun_nxt = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nxt = ST_WAIT;
                    dly_nxt   = DLY_W'(1);
                    busy_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Counter started at 1 on the fall edge, so equality with
                // CAP_DLY lands exactly CAP_DLY edges after the fall.
                if (dly_r == DLY_DONE) begin
                    snap_en_s  = 1'b1;
                    state_nxt  = ST_SEND;
                    dly_nxt    = '0;
                    idx_nxt    = '0;
                    tdata_nxt  = HDR;
                    tvalid_nxt = 1'b1;
                end else begin
                    dly_nxt = dly_r + DLY_W'(1);
                end
            end
            ST_SEND: begin
                if (tvalid_r && i_tready) begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt  = ST_IDLE;
                        idx_nxt    = '0;
                        tdata_nxt  = 8'h00;
                        tvalid_nxt = 1'b0;
                        busy_nxt   = 1'b0;
                    end else begin
                        idx_nxt   = idx_r + IDX_W'(1);
                        tdata_nxt = frame_byte(frame_r, idx_r + IDX_W'(1));
                    end
                end else begin
                    idx_nxt = idx_r;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                dly_nxt    = '0;
                idx_nxt    = '0;
                tdata_nxt  = 8'h00;
                tvalid_nxt = 1'b0;
                busy_nxt   = 1'b0;
            end
        endcase
    end

    // Counters and registered stream/status outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dly_r     <= '0;
            idx_r     <= '0;
            tdata_r   <= 8'h00;
            tvalid_r  <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            dly_r     <= dly_nxt;
            idx_r     <= idx_nxt;
            tdata_r   <= tdata_nxt;
            tvalid_r  <= tvalid_nxt;
            busy_r    <= busy_nxt;
            overrun_r <= overrun_nxt;
        end
    end

    // Frame snapshot, loaded once per accepted window close.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            frame_r <= '0;
        end else if (snap_en_s) begin
            frame_r <= frame_new_s;
        end else begin
            frame_r <= frame_r;
        end
    end

endmodule

// File: tb/tb_pulse_cnt_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_pulse_cnt_frame_tx
//   Directed bench for pulse_cnt_frame_tx. Expected frame bytes are pushed to
//   a queue when a window close is driven and popped whenever the DUT
//   transfers a byte (sampled on the falling clock edge).
// ---------------------------------------------------------------------------
module tb_pulse_cnt_frame_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_en;
    logic [15:0] i_cnt0, i_cnt1, i_cnt2, i_cnt3;
    logic [7:0]  o_tdata;
    logic        o_tvalid;
    logic        i_tready;
    logic        o_busy;
    logic        o_overrun;

    int          errors = 0;
    int          checks = 0;
    int          frame_acc = 0;
    int          ovr_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  hold_data;

    pulse_cnt_frame_tx #(
        .CNT_W   (16),
        .CAP_DLY (2),
        .HDR     (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (i_en),
        .i_cnt0    (i_cnt0),
        .i_cnt1    (i_cnt1),
        .i_cnt2    (i_cnt2),
        .i_cnt3    (i_cnt3),
        .o_tdata   (o_tdata),
        .o_tvalid  (o_tvalid),
        .i_tready  (i_tready),
        .o_busy    (o_busy),
        .o_overrun (o_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor at negedge, then step past the rising edge.
    task automatic cycle();
        logic [7:0] e;
        @(negedge clk);
        if (o_overrun === 1'b1) ovr_cnt++;
        if (o_tvalid === 1'b1 && i_tready === 1'b1) begin
            frame_acc++;
            chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tdata", 32'(o_tdata), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_lit(input logic [79:0] v);
        for (int i = 9; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic push_model(input logic [15:0] c0, input logic [15:0] c1,
                              input logic [15:0] c2, input logic [15:0] c3);
        logic [63:0] body;
        logic [7:0]  x;
        body = {c0, c1, c2, c3};
        x = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(body[i*8 +: 8]);
            x = x ^ body[i*8 +: 8];
        end
        exp_q.push_back(x);
    endtask

    task automatic set_cnt(input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] c2, input logic [15:0] c3);
        i_cnt0 = c0; i_cnt1 = c1; i_cnt2 = c2; i_cnt3 = c3;
    endtask

    // Open the window for two cycles, then close it; the next edge is E0.
    task automatic close_window();
        i_en = 1'b1;
        cycle();
        cycle();
        i_en = 1'b0;
    endtask

    task automatic wait_acc(input int n);
        int budget;
        budget = 200;
        while (frame_acc < n && budget > 0) begin
            cycle();
            budget--;
        end
        chk("wait_acc_timeout", 32'(frame_acc >= n), 32'd1);
    endtask

    task automatic wait_frame_done(input string tag);
        int budget;
        budget = 300;
        while (exp_q.size() != 0 && budget > 0) begin
            cycle();
            budget--;
        end
        chk({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_busy_low"}, 32'(o_busy), 32'd0);
        chk({tag, "_tvalid_low"}, 32'(o_tvalid), 32'd0);
        chk({tag, "_len"}, 32'(frame_acc), 32'd10);
    endtask

    initial begin
        rst_n    = 1'b1;
        i_en     = 1'b0;
        i_tready = 1'b1;
        set_cnt(16'd0, 16'd0, 16'd0, 16'd0);

        // Reset state
        cycle();
        cycle();
        chk("rst_tdata", 32'(o_tdata), 32'd0);
        chk("rst_tvalid", 32'(o_tvalid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_overrun", 32'(o_overrun), 32'd0);
        rst_n = 1'b0;
        // i_en low at release must not count as a fall
        for (int i = 0; i < 5; i++) cycle();
        chk("no_fall_at_release", 32'(o_busy), 32'd0);
        chk("no_bytes_at_release", 32'(frame_acc), 32'd0);

        // 1: basic frame and latency
        set_cnt(16'd0, 16'd50, 16'd50, 16'd50);
        close_window();
        push_lit(80'hA5_0000_0032_0032_0032_97);
        frame_acc = 0;
        cycle();                                  // E0
        chk("t1_busy_e0", 32'(o_busy), 32'd1);
        chk("t1_tvalid_e0", 32'(o_tvalid), 32'd0);
        cycle();                                  // E0+1
        chk("t1_tvalid_e1", 32'(o_tvalid), 32'd0);
        cycle();                                  // E0+2
        chk("t1_tvalid_e2", 32'(o_tvalid), 32'd1);
        chk("t1_hdr", 32'(o_tdata), 32'hA5);
        wait_frame_done("t1");

        // 2: checksum patterns
        set_cnt(16'h0045, 16'h0045, 16'h0045, 16'h0000);
        close_window();
        push_lit(80'hA5_0045_0045_0045_0000_E0);
        frame_acc = 0;
        wait_frame_done("t2a");
        set_cnt(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        close_window();
        push_lit(80'hA5_FFFF_0000_0000_0000_A5);
        frame_acc = 0;
        wait_frame_done("t2b");

        // 3: backpressure while byte index 3 is presented
        set_cnt(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        close_window();
        push_model(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        frame_acc = 0;
        wait_acc(3);
        i_tready = 1'b0;
        hold_data = o_tdata;
        chk("t3_idx3_byte", 32'(hold_data), 32'(exp_q[0]));
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_hold_tvalid", 32'(o_tvalid), 32'd1);
            chk("t3_hold_tdata", 32'(o_tdata), 32'(hold_data));
        end
        i_tready = 1'b1;
        wait_frame_done("t3");

        // 4: overrun during SEND
        set_cnt(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        close_window();
        push_model(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        frame_acc = 0;
        ovr_cnt = 0;
        wait_acc(2);
        set_cnt(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
        i_en = 1'b1;
        cycle();
        i_en = 1'b0;
        cycle();                                  // second fall edge
        chk("t4_overrun_pulse", 32'(o_overrun), 32'd1);
        cycle();
        chk("t4_overrun_clear", 32'(o_overrun), 32'd0);
        wait_frame_done("t4");
        for (int i = 0; i < 20; i++) cycle();
        chk("t4_overrun_count", 32'(ovr_cnt), 32'd1);
        chk("t4_single_frame", 32'(frame_acc), 32'd10);

        // 5: reset mid-frame
        set_cnt(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        close_window();
        push_model(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        frame_acc = 0;
        wait_acc(4);
        rst_n = 1'b1;
        #1;
        chk("t5_tvalid_async", 32'(o_tvalid), 32'd0);
        chk("t5_busy_async", 32'(o_busy), 32'd0);
        exp_q.delete();
        cycle();
        cycle();
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        chk("t5_no_more_bytes", 32'(frame_acc), 32'd4);
        chk("t5_busy_idle", 32'(o_busy), 32'd0);

        // 6: glitchy enable, counts sampled only at E0+2
        set_cnt(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
        close_window();
        frame_acc = 0;
        cycle();                                  // E0
        i_en = 1'b1;
        set_cnt(16'h1A1A, 16'h1B1B, 16'h1C1C, 16'h1D1D);
        cycle();                                  // E0+1
        set_cnt(16'h2468, 16'h1357, 16'hFEDC, 16'h8001);
        push_model(16'h2468, 16'h1357, 16'hFEDC, 16'h8001);
        cycle();                                  // E0+2 snapshot
        chk("t6_tvalid", 32'(o_tvalid), 32'd1);
        set_cnt(16'h5555, 16'h6666, 16'h7777, 16'h9999);
        wait_frame_done("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
